// File: rtl/control_unit_p.sv
// control_unit_p: fetch/execute sequencer for the accumulator datapath with a
// general-register file, memory-ready stalls, start/halt control and trapping.
module control_unit_p #(
  parameter int unsigned NUM_GPR = 5,
  localparam int unsigned WE_W   = 8 + NUM_GPR,
  localparam int unsigned BUS_W  = $clog2(7 + NUM_GPR)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       ir,
  input  logic             z,
  input  logic             mem_ready,
  output logic [WE_W-1:0]  write_en,
  output logic [BUS_W-1:0] bus_ld,
  output logic [1:0]       inc,
  output logic [3:0]       alu_mode,
  output logic [2:0]       clr,
  output logic             dm_wr,
  output logic             im_wr,
  output logic             end_op,
  output logic             illegal,
  output logic             busy
);

  // Fixed datapath register positions at the top of write_en.
  localparam int unsigned WeArb = WE_W - 1;
  localparam int unsigned WeAr  = WE_W - 2;
  localparam int unsigned WePc  = WE_W - 3;
  localparam int unsigned WeDr  = WE_W - 4;
  localparam int unsigned WeIr  = WE_W - 5;
  localparam int unsigned WeAc  = WE_W - 8;

  localparam logic [3:0] OpNop   = 4'd0;
  localparam logic [3:0] OpLdaci = 4'd1;
  localparam logic [3:0] OpStaci = 4'd2;
  localparam logic [3:0] OpMvacr = 4'd3;
  localparam logic [3:0] OpMvrac = 4'd4;
  localparam logic [3:0] OpAdd   = 4'd5;
  localparam logic [3:0] OpSub   = 4'd6;
  localparam logic [3:0] OpMul   = 4'd7;
  localparam logic [3:0] OpLdar  = 4'd8;
  localparam logic [3:0] OpClr   = 4'd9;
  localparam logic [3:0] OpIncac = 4'd10;
  localparam logic [3:0] OpJpnz  = 4'd11;
  localparam logic [3:0] OpJpz   = 4'd12;
  localparam logic [3:0] OpEndop = 4'd13;

  typedef enum logic [3:0] {
    StIdle, StFetch1, StFetch2, StFetch3, StExec1, StExec2, StExec3, StExec4, StHalt
  } state_t;

  state_t state;
  logic   illegal_q;

  logic [3:0]       op;
  logic [3:0]       rsel;
  logic             gpr_op;
  logic             illegal_op;
  logic             jump_op;
  logic             jump_taken;
  logic [BUS_W-1:0] gpr_bus;

  // Instruction decode shared by sequencing and strobe generation.
  always_comb begin
    op         = ir[7:4];
    rsel       = ir[3:0];
    gpr_op     = (op >= OpMvacr) && (op <= OpLdar);
    illegal_op = (op > OpEndop) || (gpr_op && (32'(rsel) >= NUM_GPR));
    jump_op    = (op == OpJpnz) || (op == OpJpz);
    jump_taken = ((op == OpJpnz) && !z) || ((op == OpJpz) && z);
    gpr_bus    = BUS_W'(32'd7 + 32'(rsel));
  end

  // State sequencing and the sticky illegal-instruction flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= StIdle;
      illegal_q <= 1'b0;
    end else begin
      unique case (state)
        StIdle:   if (start) state <= StFetch1;
        StHalt: begin
          if (start) begin
            state     <= StFetch1;
            illegal_q <= 1'b0;
          end
        end
        StFetch1: state <= StFetch2;
        StFetch2: if (mem_ready) state <= StFetch3;
        StFetch3: state <= StExec1;
        StExec1: begin
          if (illegal_op) begin
            illegal_q <= 1'b1;
            state     <= StHalt;
          end else if ((op == OpLdaci) || (op == OpStaci)) begin
            if (mem_ready) state <= StExec2;
          end else if (jump_op) begin
            if (!jump_taken)    state <= StFetch1;
            else if (mem_ready) state <= StExec2;
          end else if (op == OpEndop) begin
            state <= StHalt;
          end else begin
            state <= StFetch1;
          end
        end
        StExec2:  state <= jump_op ? StFetch1 : StExec3;
        StExec3: begin
          if (op == OpStaci)  state <= StFetch1;
          else if (mem_ready) state <= StExec4;
        end
        StExec4:  state <= StFetch1;
        default:  state <= StIdle;
      endcase
    end
  end

  // Control strobes decoded from the current state (plus ir/z/mem_ready in read states).
  always_comb begin
    write_en = '0;
    bus_ld   = '0;
    inc      = 2'b00;
    alu_mode = 4'd0;
    clr      = 3'b000;
    dm_wr    = 1'b0;
    end_op   = 1'b0;
    unique case (state)
      StIdle:   clr = 3'b111;
      StFetch1: begin
        bus_ld         = BUS_W'(2);
        write_en[WeAr] = 1'b1;
      end
      StFetch2: begin
        bus_ld = BUS_W'(0);
        if (mem_ready) begin
          write_en[WeDr] = 1'b1;
          inc            = 2'b01;
        end
      end
      StFetch3: begin
        bus_ld         = BUS_W'(3);
        write_en[WeIr] = 1'b1;
      end
      StExec1: begin
        if (!illegal_op) begin
          unique case (op)
            OpMvacr: begin
              bus_ld         = BUS_W'(5);
              write_en[rsel] = 1'b1;
            end
            OpMvrac, OpAdd, OpSub, OpMul: begin
              bus_ld         = gpr_bus;
              write_en[WeAc] = 1'b1;
              alu_mode       = (op == OpMvrac) ? 4'd5 : (op - OpAdd);
            end
            OpLdar: begin
              bus_ld          = gpr_bus;
              write_en[WeArb] = 1'b1;
              write_en[WeAr]  = 1'b1;
            end
            OpClr:   clr = rsel[2:0];
            OpIncac: inc = 2'b10;
            OpLdaci, OpStaci: begin
              bus_ld         = BUS_W'(0);
              write_en[WeDr] = mem_ready;
            end
            OpJpnz, OpJpz: begin
              if (jump_taken) begin
                bus_ld         = BUS_W'(0);
                write_en[WeDr] = mem_ready;
              end else begin
                inc = 2'b01;
              end
            end
            OpEndop: end_op = 1'b1;
            default: ;
          endcase
        end
      end
      StExec2: begin
        bus_ld = BUS_W'(3);
        if (jump_op) begin
          write_en[WePc] = 1'b1;
        end else begin
          write_en[WeArb] = 1'b1;
          write_en[WeAr]  = 1'b1;
          inc             = 2'b01;
        end
      end
      StExec3: begin
        if (op == OpStaci) begin
          bus_ld = BUS_W'(5);
          dm_wr  = 1'b1;
        end else begin
          bus_ld         = BUS_W'(1);
          write_en[WeDr] = mem_ready;
        end
      end
      StExec4: begin
        bus_ld         = BUS_W'(3);
        write_en[WeAc] = 1'b1;
        alu_mode       = 4'd5;
      end
      default: ;
    endcase
  end

  assign im_wr   = 1'b0;
  assign illegal = illegal_q;
  assign busy    = (state != StIdle) && (state != StHalt);

  // Opcode OpNop needs no strobes; keep the name referenced for readers.
  logic unused_nop;
  assign unused_nop = (op == OpNop);

endmodule

// File: tb/tb_control_unit_p.sv
// Scoreboard bench for control_unit_p: the driver pushes the expected strobe set
// for every cycle it drives; a negedge monitor pops and compares.
module tb_control_unit_p;

  localparam int NG = 5;

  logic        clk = 1'b0;
  logic        rst_n, start, z, mem_ready;
  logic [7:0]  ir;
  logic [12:0] write_en;
  logic [3:0]  bus_ld;
  logic [1:0]  inc;
  logic [3:0]  alu_mode;
  logic [2:0]  clr;
  logic        dm_wr, im_wr, end_op, illegal, busy;

  control_unit_p #(.NUM_GPR(NG)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ir(ir), .z(z), .mem_ready(mem_ready),
    .write_en(write_en), .bus_ld(bus_ld), .inc(inc), .alu_mode(alu_mode), .clr(clr),
    .dm_wr(dm_wr), .im_wr(im_wr), .end_op(end_op), .illegal(illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [12:0] we;
    logic [3:0]  bus;
    logic [1:0]  inc;
    logic [3:0]  alu;
    logic [2:0]  clr;
    logic        dm;
    logic        im;
    logic        eo;
    logic        busy;
    logic        ill;
  } obs_t;

  localparam logic [12:0] ARB = 13'h1000;
  localparam logic [12:0] AR  = 13'h0800;
  localparam logic [12:0] PC  = 13'h0400;
  localparam logic [12:0] DR  = 13'h0200;
  localparam logic [12:0] IRW = 13'h0100;
  localparam logic [12:0] AC  = 13'h0020;

  obs_t q[$];
  int   checks = 0;
  int   passed = 0;
  int   cyc_no = 0;
  logic ill_m  = 1'b0;

  function automatic obs_t mk(logic [12:0] we, logic [3:0] bus, logic [1:0] inc_v,
                              logic [3:0] alu, logic [2:0] clr_v, logic dm, logic eo,
                              logic bz, logic il);
    obs_t o;
    o.we = we; o.bus = bus; o.inc = inc_v; o.alu = alu; o.clr = clr_v;
    o.dm = dm; o.im = 1'b0; o.eo = eo; o.busy = bz; o.ill = il;
    return o;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic obs_t idle_o();
    return mk(13'h0, 4'd0, 2'b00, 4'd0, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic obs_t busy_o(logic [12:0] we, logic [3:0] bus, logic [1:0] inc_v,
                                  logic [3:0] alu);
    return mk(we, bus, inc_v, alu, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
  endfunction

  // Monitor: one comparison per driven cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      obs_t e, a;
      e = q.pop_front();
      a = '{write_en, bus_ld, inc, alu_mode, clr, dm_wr, im_wr, end_op, busy, illegal};
      checks++;
      cyc_no++;
      if (a === e) passed++;
      else
        $display("FAIL strobes cycle %0d: got we=%h bus=%0d inc=%b alu=%0d clr=%b dm=%b im=%b eo=%b busy=%b ill=%b, want we=%h bus=%0d inc=%b alu=%0d clr=%b dm=%b im=%b eo=%b busy=%b ill=%b",
                 cyc_no, a.we, a.bus, a.inc, a.alu, a.clr, a.dm, a.im, a.eo, a.busy, a.ill,
                 e.we, e.bus, e.inc, e.alu, e.clr, e.dm, e.im, e.eo, e.busy, e.ill);
    end
  end

  task automatic cyc(input logic mr, input logic st, input logic rn, input obs_t e);
    mem_ready = mr;
    start     = st;
    rst_n     = rn;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // A memory read: 'stalls' cycles without data, then the completing cycle.
  task automatic rd(input logic [3:0] bus, input logic [1:0] inc_done, input int stalls);
    repeat (stalls) cyc(1'b0, rb(), 1'b1, busy_o(13'h0, bus, 2'b00, 4'd0));
    cyc(1'b1, rb(), 1'b1, busy_o(DR, bus, inc_done, 4'd0));
  endtask

  task automatic fetch(input int s0);
    cyc(rb(), rb(), 1'b1, busy_o(AR, 4'd2, 2'b00, 4'd0));
    rd(4'd0, 2'b01, s0);
    cyc(rb(), rb(), 1'b1, busy_o(IRW, 4'd3, 2'b00, 4'd0));
  endtask

  // Halted: everything low except the trap flag; start returns to fetching.
  task automatic do_halt(input int n);
    obs_t h;
    h = mk(13'h0, 4'd0, 2'b00, 4'd0, 3'b000, 1'b0, 1'b0, 1'b0, ill_m);
    repeat (n) cyc(rb(), 1'b0, 1'b1, h);
    cyc(rb(), 1'b1, 1'b1, h);
    ill_m = 1'b0;
  endtask

  // Reference behaviour of one instruction starting in the first fetch cycle.
  task automatic run_instr(input logic [7:0] iv, input logic zv, input int s0, input int s1,
                           input int s2, output bit halted);
    int op, r;
    bit bad, taken;
    logic [12:0] g;
    op = int'(iv[7:4]);
    r  = int'(iv[3:0]);
    g  = 13'd1 << r;
    bad = (op >= 14) || (op >= 3 && op <= 8 && r >= NG);
    halted = 1'b0;
    ir = iv;
    z  = zv;
    fetch(s0);
    if (bad) begin
      cyc(rb(), rb(), 1'b1, busy_o(13'h0, 4'd0, 2'b00, 4'd0));
      ill_m  = 1'b1;
      halted = 1'b1;
    end else begin
      case (op)
        3:  cyc(rb(), rb(), 1'b1, busy_o(g, 4'd5, 2'b00, 4'd0));
        4:  cyc(rb(), rb(), 1'b1, busy_o(AC, 4'(7 + r), 2'b00, 4'd5));
        5, 6, 7: cyc(rb(), rb(), 1'b1, busy_o(AC, 4'(7 + r), 2'b00, 4'(op - 5)));
        8:  cyc(rb(), rb(), 1'b1, busy_o(ARB | AR, 4'(7 + r), 2'b00, 4'd0));
        9:  cyc(rb(), rb(), 1'b1, mk(13'h0, 4'd0, 2'b00, 4'd0, iv[2:0], 1'b0, 1'b0, 1'b1, 1'b0));
        10: cyc(rb(), rb(), 1'b1, busy_o(13'h0, 4'd0, 2'b10, 4'd0));
        1, 2: begin
          rd(4'd0, 2'b00, s1);
          cyc(rb(), rb(), 1'b1, busy_o(ARB | AR, 4'd3, 2'b01, 4'd0));
          if (op == 2) begin
            cyc(rb(), rb(), 1'b1, mk(13'h0, 4'd5, 2'b00, 4'd0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0));
          end else begin
            rd(4'd1, 2'b00, s2);
            cyc(rb(), rb(), 1'b1, busy_o(AC, 4'd3, 2'b00, 4'd5));
          end
        end
        11, 12: begin
          taken = (op == 11) ? !zv : zv;
          if (taken) begin
            rd(4'd0, 2'b00, s1);
            cyc(rb(), rb(), 1'b1, busy_o(PC, 4'd3, 2'b00, 4'd0));
          end else begin
            cyc(rb(), rb(), 1'b1, busy_o(13'h0, 4'd0, 2'b01, 4'd0));
          end
        end
        13: begin
          cyc(rb(), rb(), 1'b1, mk(13'h0, 4'd0, 2'b00, 4'd0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0));
          halted = 1'b1;
        end
        default: cyc(rb(), rb(), 1'b1, busy_o(13'h0, 4'd0, 2'b00, 4'd0));
      endcase
    end
  endtask

  initial begin
    bit h;
    rst_n = 1'b0; start = 1'b1; ir = 8'h00; z = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    // Reset beats a simultaneous start.
    cyc(1'b0, 1'b1, 1'b0, idle_o());
    cyc(1'b0, 1'b1, 1'b0, idle_o());
    cyc(rb(), 1'b0, 1'b1, idle_o());
    cyc(rb(), 1'b1, 1'b1, idle_o());

    run_instr(8'h00, 1'b0, 0, 0, 0, h);   // NOP
    run_instr(8'h52, 1'b0, 0, 0, 0, h);   // ADD R2
    run_instr(8'h57, 1'b0, 0, 0, 0, h);   // ADD R7: bad register
    do_halt(2);
    run_instr(8'h10, 1'b0, 2, 0, 3, h);   // LDACI with stalls
    run_instr(8'hB0, 1'b0, 0, 1, 0, h);   // JPNZ taken
    run_instr(8'hB0, 1'b1, 0, 0, 0, h);   // JPNZ not taken
    run_instr(8'hC0, 1'b1, 1, 0, 0, h);   // JPZ taken
    run_instr(8'h20, 1'b0, 0, 2, 0, h);   // STACI
    run_instr(8'h34, 1'b0, 0, 0, 0, h);   // MVACR R4
    run_instr(8'h9D, 1'b0, 0, 0, 0, h);   // CLR with rsel[2:0]=101
    run_instr(8'hE0, 1'b0, 0, 0, 0, h);   // illegal opcode
    // Reset while halted clears the trap flag.
    cyc(rb(), 1'b0, 1'b0, mk(13'h0, 4'd0, 2'b00, 4'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1));
    ill_m = 1'b0;
    cyc(rb(), 1'b1, 1'b1, idle_o());
    run_instr(8'hD0, 1'b0, 0, 0, 0, h);   // ENDOP
    do_halt(1);

    // Reset during the STACI memory-write cycle aborts back to IDLE.
    ir = 8'h20;
    fetch(0);
    rd(4'd0, 2'b00, 0);
    cyc(rb(), rb(), 1'b1, busy_o(ARB | AR, 4'd3, 2'b01, 4'd0));
    cyc(rb(), 1'b0, 1'b0, mk(13'h0, 4'd5, 2'b00, 4'd0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0));
    cyc(rb(), 1'b0, 1'b1, idle_o());
    cyc(rb(), 1'b1, 1'b1, idle_o());

    // Random instruction stream.
    for (int i = 0; i < 300; i++) begin
      run_instr(8'($urandom), rb(), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), h);
      if (h) do_halt($urandom_range(0, 2));
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() == 0) passed++;
    else $display("FAIL drain: got %0d pending, want 0", q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/control_unit_p.md
# control_unit_p

Parametrised successor to the accumulator-CPU control FSM; it sequences fetch and execute for the single-core matrix-multiply datapath. It adds a configurable general-register file (one register field replaces per-register opcodes), a memory-ready stall handshake, start/halt control, Z and NZ jumps, and illegal-instruction trapping. All control strobes are decoded from the current state (Moore) and drive the datapath bus mux, register write enables, incrementers, clears and memory writes.

## Interface
- NUM_GPR, 5, number of general registers R0..R(NUM_GPR-1), legal 1..9
- WE_W, 8+NUM_GPR, write-enable width (derived, not overridden)
- BUS_W, clog2(7+NUM_GPR), bus-select width (derived)
- clk  in  1  clock, all state changes on rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  leave IDLE/HALT and begin fetching
- ir  in  8  instruction register; op=ir[7:4], rsel=ir[3:0]
- z  in  1  AC-zero flag
- mem_ready  in  1  IMEM/DMEM read data valid this cycle
- write_en  out  WE_W  one-hot-ish; bit WE_W-1..WE_W-8 = ARB,AR,PC,DR,IR,R,TR,AC; bit k = GPR k
- bus_ld  out  BUS_W  0 IMEM,1 DMEM,2 PC,3 DR,4 R,5 AC,6 TR,7+k GPR k
- inc  out  2  00 none, 01 PC, 10 AC
- alu_mode  out  4  0 add,1 sub,2 mul,5 pass
- clr  out  3  bit2 AC, bit1 TR, bit0 R
- dm_wr, im_wr  out  1  memory writes (im_wr constant 0)
- end_op  out  1  one-cycle pulse on ENDOP
- illegal  out  1  sticky trap flag
- busy  out  1  high in any state except IDLE/HALT

## Operation
- States: IDLE, FETCH1, FETCH2, FETCH3, EXEC1..EXEC4, HALT. Unlisted outputs are 0 in every state.
- IDLE: clr=111; start -> FETCH1. HALT: all outputs 0 except illegal; start -> FETCH1 with illegal cleared.
- FETCH1: bus 2, we AR -> FETCH2. FETCH2: bus 0; when mem_ready: we DR, inc PC -> FETCH3, else hold with no strobes. FETCH3: bus 3, we IR -> EXEC1.
- EXEC1 decode by op (rsel must be < NUM_GPR for GPR ops, else illegal):
- 0 NOP -> FETCH1. 3 MVACR: bus 5, we GPR[rsel]. 4 MVRAC: bus GPR, we AC, alu 5. 5/6/7 ADD/SUB/MUL: bus GPR, we AC, alu 0/1/2. 8 LDAR: bus GPR, we ARB|AR. 9 CLR: clr=rsel[2:0]. 10 INCAC: inc 10. All -> FETCH1.
- 1 LDACI / 2 STACI: EXEC1 bus 0, we DR on mem_ready (stall as FETCH2); EXEC2 bus 3, we ARB|AR, inc PC; LDACI EXEC3 bus 1, we DR on mem_ready (stall); EXEC4 bus 3, we AC, alu 5 -> FETCH1. STACI EXEC3 bus 5, dm_wr=1 -> FETCH1.
- 11 JPNZ / 12 JPZ: z sampled in EXEC1. Taken (z=0 / z=1): EXEC1 bus 0, we DR on mem_ready (stall); EXEC2 bus 3, we PC -> FETCH1. Not taken: EXEC1 inc PC -> FETCH1.
- 13 ENDOP: end_op=1 for the EXEC1 cycle -> HALT.
- 14, 15, or bad rsel: no strobes, illegal set in EXEC1 (registered, visible next cycle) -> HALT.

## Timing
- Reset: state IDLE, illegal 0; outputs as IDLE (clr=111, rest 0). Reset mid-instruction aborts with no further strobes; a stalled read is abandoned.
- Outputs combinational from registered state, z, ir, mem_ready; no output register delay.
- Cycles with mem_ready=1: NOP/ALU/move 4, jump not taken 4, jump taken 5, STACI 6, LDACI 7. Each low mem_ready cycle in a read state adds one.
- start ignored outside IDLE/HALT; start and rst_n low together: reset wins.
- Every write_en pattern has at most the listed bits; dm_wr never coincides with any write_en bit.

## Test plan
- Reset then start, ir=0x00, mem_ready=1 -> FETCH1..EXEC1 strobes exactly as listed, busy=1, back to FETCH1 after 4 cycles.
- ir=0x52 (ADD R2), NUM_GPR=5 -> EXEC1 bus_ld=9, write_en=AC bit only, alu_mode=0; ir=0x57 -> illegal=1, HALT.
- LDACI with mem_ready low 2 cycles in FETCH2 and 3 in EXEC3 -> 12 total cycles, DR written once per read, dm_wr never 1.
- JPNZ z=0 -> PC write in EXEC2 with bus_ld=3; z=1 -> inc=01 in EXEC1, 4 cycles.
- ENDOP -> end_op high exactly one cycle, HALT, outputs 0; start -> FETCH1.
- rst_n low during EXEC3 of STACI -> dm_wr 0 after edge, state IDLE, clr=111.
